// File: rtl/decode_stage_piped.sv
// MIPS decode stage: register file with write-first bypass, main decoder,
// load-use hazard detection, jump redirect and the ID/EX pipeline register.
module decode_stage_piped #(
  parameter  int DATA_W    = 32,
  parameter  int REG_COUNT = 32,
  localparam int REG_AW    = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_in,
  input  logic [DATA_W-1:0] pc4_in,
  input  logic              in_valid,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall_out,
  output logic              jump_out,
  output logic [DATA_W-1:0] pc_jump_out,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_alu_src,
  output logic              ex_reg_dst,
  output logic [1:0]        ex_branch,
  output logic [5:0]        ex_opcode,
  output logic [5:0]        ex_func,
  output logic [REG_AW-1:0] ex_rs_addr,
  output logic [REG_AW-1:0] ex_rt_addr,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] branch;
  } ctrl_t;

  logic [5:0]        opcode;
  logic [5:0]        func;
  logic [REG_AW-1:0] rs_addr;
  logic [REG_AW-1:0] rt_addr;
  logic [REG_AW-1:0] rd_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] imm;
  ctrl_t             dec_ctrl;
  ctrl_t             ex_ctrl;
  logic              uses_rt;
  logic              hazard;
  logic              bubble;

  logic [DATA_W-1:0] regs [REG_COUNT];

  assign opcode  = instr_in[31:26];
  assign func    = instr_in[5:0];
  assign rs_addr = instr_in[21 +: REG_AW];
  assign rt_addr = instr_in[16 +: REG_AW];
  assign rd_addr = instr_in[11 +: REG_AW];
  assign imm     = {{(DATA_W-16){instr_in[15]}}, instr_in[15:0]};

  // NOTE: the register file is reset entry by entry because reset must
  // leave every register reading zero; this rules out a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wb_we && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Write-first read: a same-cycle writeback to a read register wins.
  always_comb begin
    rs_data = regs[rs_addr];
    rt_data = regs[rt_addr];
    if (rs_addr == '0)                       rs_data = '0;
    else if (wb_we && wb_addr == rs_addr)    rs_data = wb_data;
    if (rt_addr == '0)                       rt_data = '0;
    else if (wb_we && wb_addr == rt_addr)    rt_data = wb_data;
  end

  // NOTE: every output of this block gets a default before the case so
  // unlisted opcodes decode to zero controls and no latch is inferred.
  always_comb begin
    dec_ctrl = '0;
    uses_rt  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.reg_dst   = 1'b1;
        uses_rt            = 1'b1;
      end
      OP_LW: begin
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
      end
      OP_SW: begin
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        uses_rt            = 1'b1;
      end
      OP_BEQ: begin
        dec_ctrl.branch = 2'b01;
        uses_rt         = 1'b1;
      end
      OP_BNE: begin
        dec_ctrl.branch = 2'b10;
        uses_rt         = 1'b1;
      end
      OP_ADDI: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
      end
      default: ;
    endcase
  end

  // A bubble in EX has mem_read=0, so a load-use stall lasts one cycle.
  assign hazard = ex_valid && ex_ctrl.mem_read && (ex_rt_addr != '0) && in_valid &&
                  ((ex_rt_addr == rs_addr) || (uses_rt && ex_rt_addr == rt_addr));

  assign stall_out   = hazard && !flush;
  assign jump_out    = in_valid && (opcode == OP_J) && !stall_out && !flush;
  assign pc_jump_out = {pc4_in[DATA_W-1:28], instr_in[25:0], 2'b00};
  assign bubble      = !in_valid || flush || hazard;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_opcode  <= '0;
      ex_func    <= '0;
      ex_rs_addr <= '0;
      ex_rt_addr <= '0;
      ex_rd_addr <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_pc4     <= '0;
    end else begin
      ex_valid   <= !bubble;
      ex_ctrl    <= bubble ? '0 : dec_ctrl;
      ex_opcode  <= opcode;
      ex_func    <= func;
      ex_rs_addr <= rs_addr;
      ex_rt_addr <= rt_addr;
      ex_rd_addr <= rd_addr;
      ex_rs_data <= rs_data;
      ex_rt_data <= rt_data;
      ex_imm     <= imm;
      ex_pc4     <= pc4_in;
    end
  end

  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_reg_dst    = ex_ctrl.reg_dst;
  assign ex_branch     = ex_ctrl.branch;

endmodule

// File: tb/tb_decode_stage_piped.sv
// Scoreboard bench for decode_stage_piped: stimulus pushes expected ID/EX
// records, monitors pop them whenever a DUT presents ex_valid.
module tb_decode_stage_piped;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Control vector order: {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, branch[1:0]}
  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_R    = 8'b1000_0100;
  localparam logic [7:0] C_LW   = 8'b1101_1000;
  localparam logic [7:0] C_SW   = 8'b0010_1000;
  localparam logic [7:0] C_ADDI = 8'b1000_1000;
  localparam logic [7:0] C_BEQ  = 8'b0000_0001;
  localparam logic [7:0] C_BNE  = 8'b0000_0010;

  typedef struct packed {
    logic [7:0]  ctl;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs_a;
    logic [4:0]  rt_a;
    logic [4:0]  rd_a;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic [31:0] imm;
    logic [31:0] pc4;
  } rec_t;

  rec_t q32[$];
  rec_t q16[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // 32-entry instance
  logic [31:0] instr, pc4, pc_jump;
  logic        in_valid, flush, wb_we, stall, jump;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst;
  logic [1:0]  ex_branch;
  logic [5:0]  ex_opcode, ex_func;
  logic [4:0]  ex_rs_addr, ex_rt_addr, ex_rd_addr;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;

  // 16-entry instance
  logic [31:0] h_instr, h_pc4, h_pc_jump;
  logic        h_in_valid, h_flush, h_wb_we, h_stall, h_jump;
  logic [3:0]  h_wb_addr;
  logic [31:0] h_wb_data;
  logic        h_ex_valid, h_ex_reg_write, h_ex_mem_read, h_ex_mem_write, h_ex_mem_to_reg, h_ex_alu_src, h_ex_reg_dst;
  logic [1:0]  h_ex_branch;
  logic [5:0]  h_ex_opcode, h_ex_func;
  logic [3:0]  h_ex_rs_addr, h_ex_rt_addr, h_ex_rd_addr;
  logic [31:0] h_ex_rs_data, h_ex_rt_data, h_ex_imm, h_ex_pc4;

  decode_stage_piped #(.DATA_W(32), .REG_COUNT(32)) dut (
    .clk(clk), .reset(reset), .instr_in(instr), .pc4_in(pc4), .in_valid(in_valid), .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall_out(stall), .jump_out(jump), .pc_jump_out(pc_jump),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src),
    .ex_reg_dst(ex_reg_dst), .ex_branch(ex_branch), .ex_opcode(ex_opcode), .ex_func(ex_func),
    .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_rd_addr(ex_rd_addr),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc4(ex_pc4)
  );

  decode_stage_piped #(.DATA_W(32), .REG_COUNT(16)) dut16 (
    .clk(clk), .reset(reset), .instr_in(h_instr), .pc4_in(h_pc4), .in_valid(h_in_valid), .flush(h_flush),
    .wb_we(h_wb_we), .wb_addr(h_wb_addr), .wb_data(h_wb_data),
    .stall_out(h_stall), .jump_out(h_jump), .pc_jump_out(h_pc_jump),
    .ex_valid(h_ex_valid), .ex_reg_write(h_ex_reg_write), .ex_mem_read(h_ex_mem_read),
    .ex_mem_write(h_ex_mem_write), .ex_mem_to_reg(h_ex_mem_to_reg), .ex_alu_src(h_ex_alu_src),
    .ex_reg_dst(h_ex_reg_dst), .ex_branch(h_ex_branch), .ex_opcode(h_ex_opcode), .ex_func(h_ex_func),
    .ex_rs_addr(h_ex_rs_addr), .ex_rt_addr(h_ex_rt_addr), .ex_rd_addr(h_ex_rd_addr),
    .ex_rs_data(h_ex_rs_data), .ex_rt_data(h_ex_rt_data), .ex_imm(h_ex_imm), .ex_pc4(h_ex_pc4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare(input string tag, input rec_t a, input rec_t e);
    check({tag, ".ctl"},     32'(a.ctl),  32'(e.ctl));
    check({tag, ".opcode"},  32'(a.op),   32'(e.op));
    check({tag, ".func"},    32'(a.fn),   32'(e.fn));
    check({tag, ".rs_addr"}, 32'(a.rs_a), 32'(e.rs_a));
    check({tag, ".rt_addr"}, 32'(a.rt_a), 32'(e.rt_a));
    check({tag, ".rd_addr"}, 32'(a.rd_a), 32'(e.rd_a));
    check({tag, ".rs_data"}, a.rs_d, e.rs_d);
    check({tag, ".rt_data"}, a.rt_d, e.rt_d);
    check({tag, ".imm"},     a.imm,  e.imm);
    check({tag, ".pc4"},     a.pc4,  e.pc4);
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  // Expected record; addresses keep only the bits the instance decodes.
  function automatic rec_t mk(input logic [31:0] ins, input logic [31:0] pcv, input logic [7:0] ctl,
                              input logic [31:0] rsd, input logic [31:0] rtd, input logic [4:0] amask);
    rec_t r;
    r.ctl  = ctl;
    r.op   = ins[31:26];
    r.fn   = ins[5:0];
    r.rs_a = ins[25:21] & amask;
    r.rt_a = ins[20:16] & amask;
    r.rd_a = ins[15:11] & amask;
    r.rs_d = rsd;
    r.rt_d = rtd;
    r.imm  = {{16{ins[15]}}, ins[15:0]};
    r.pc4  = pcv;
    return r;
  endfunction

  // Drive one decode cycle at posedge+1; returns at posedge+3.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pcv, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    @(posedge clk);
    #1;
    in_valid = v; instr = ins; pc4 = pcv; flush = fl;
    wb_we = we; wb_addr = wa; wb_data = wd;
    #2;
  endtask

  always @(negedge clk) begin : mon32
    rec_t a, e;
    if (!reset && ex_valid) begin
      a.ctl  = {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst, ex_branch};
      a.op   = ex_opcode;   a.fn   = ex_func;
      a.rs_a = ex_rs_addr;  a.rt_a = ex_rt_addr;  a.rd_a = ex_rd_addr;
      a.rs_d = ex_rs_data;  a.rt_d = ex_rt_data;  a.imm  = ex_imm;  a.pc4 = ex_pc4;
      if (q32.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL dut32.unexpected_issue: got ex_valid=1 opcode=0x%02h, expected no issue (t=%0t)", ex_opcode, $time);
      end else begin
        e = q32.pop_front();
        compare("dut32", a, e);
      end
    end
  end

  always @(negedge clk) begin : mon16
    rec_t a, e;
    if (!reset && h_ex_valid) begin
      a.ctl  = {h_ex_reg_write, h_ex_mem_read, h_ex_mem_write, h_ex_mem_to_reg, h_ex_alu_src, h_ex_reg_dst, h_ex_branch};
      a.op   = h_ex_opcode;          a.fn   = h_ex_func;
      a.rs_a = {1'b0, h_ex_rs_addr}; a.rt_a = {1'b0, h_ex_rt_addr}; a.rd_a = {1'b0, h_ex_rd_addr};
      a.rs_d = h_ex_rs_data;         a.rt_d = h_ex_rt_data;         a.imm  = h_ex_imm;  a.pc4 = h_ex_pc4;
      if (q16.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL dut16.unexpected_issue: got ex_valid=1 opcode=0x%02h, expected no issue (t=%0t)", h_ex_opcode, $time);
      end else begin
        e = q16.pop_front();
        compare("dut16", a, e);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no end of stimulus, expected completion by 100000");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] ins;
    reset = 1'b1;
    instr = '0; pc4 = '0; in_valid = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    h_instr = '0; h_pc4 = '0; h_in_valid = 1'b0; h_flush = 1'b0; h_wb_we = 1'b0; h_wb_addr = '0; h_wb_data = '0;

    @(posedge clk); #3;
    check("rst.ex_valid", 32'(ex_valid), 32'd0);
    check("rst.ctl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst, ex_branch}), 32'd0);
    check("rst.ex_rs_data", ex_rs_data, 32'd0);
    check("rst.ex_pc4", ex_pc4, 32'd0);
    check("rst.stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // r5 <= 0x1234 (dut16: r9 <= 0x99)
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd5, 32'h1234);
    h_wb_we = 1'b1; h_wb_addr = 4'd9; h_wb_data = 32'h99;

    // add r10, r5, r6
    ins = rtype(5'd5, 5'd6, 5'd10, 6'h20);
    drive(1'b1, ins, 32'h100, 1'b0, 1'b0, 5'd0, 32'h0);
    check("add.stall", 32'(stall), 32'd0);
    check("add.jump", 32'(jump), 32'd0);
    q32.push_back(mk(ins, 32'h100, C_R, 32'h1234, 32'h0, 5'h1F));
    // dut16: fields 25/9/31 alias to r9/r9/r15
    h_wb_we = 1'b0;
    h_instr = rtype(5'd25, 5'd9, 5'd31, 6'h20); h_pc4 = 32'h200; h_in_valid = 1'b1;
    q16.push_back(mk(h_instr, 32'h200, C_R, 32'h99, 32'h99, 5'h0F));

    // add r11, r5, r7 with r7 <= 0xAA in the same cycle (bypass)
    ins = rtype(5'd5, 5'd7, 5'd11, 6'h20);
    drive(1'b1, ins, 32'h104, 1'b0, 1'b1, 5'd7, 32'hAA);
    q32.push_back(mk(ins, 32'h104, C_R, 32'h1234, 32'hAA, 5'h1F));
    h_in_valid = 1'b0;

    // sub r12, r0, r7 while writing r0
    ins = rtype(5'd0, 5'd7, 5'd12, 6'h22);
    drive(1'b1, ins, 32'h108, 1'b0, 1'b1, 5'd0, 32'hDEAD);
    q32.push_back(mk(ins, 32'h108, C_R, 32'h0, 32'hAA, 5'h1F));

    // or r13, r0, r0 after the r0 write; r3 <= 0x3333
    ins = rtype(5'd0, 5'd0, 5'd13, 6'h25);
    drive(1'b1, ins, 32'h10C, 1'b0, 1'b1, 5'd3, 32'h3333);
    q32.push_back(mk(ins, 32'h10C, C_R, 32'h0, 32'h0, 5'h1F));

    // lw r3, 8(r5)
    ins = itype(6'h23, 5'd5, 5'd3, 16'h0008);
    drive(1'b1, ins, 32'h110, 1'b0, 1'b0, 5'd0, 32'h0);
    check("lw.stall", 32'(stall), 32'd0);
    q32.push_back(mk(ins, 32'h110, C_LW, 32'h1234, 32'h3333, 5'h1F));

    // add r14, r1, r3: one stall cycle, then issue
    ins = rtype(5'd1, 5'd3, 5'd14, 6'h20);
    drive(1'b1, ins, 32'h114, 1'b0, 1'b0, 5'd0, 32'h0);
    check("loaduse.stall", 32'(stall), 32'd1);
    check("loaduse.jump", 32'(jump), 32'd0);
    drive(1'b1, ins, 32'h114, 1'b0, 1'b0, 5'd0, 32'h0);
    check("loaduse.release", 32'(stall), 32'd0);
    q32.push_back(mk(ins, 32'h114, C_R, 32'h0, 32'h3333, 5'h1F));

    // lw r3, 4(r0) then addi r3, r1, -4: rt is a destination, no stall
    ins = itype(6'h23, 5'd0, 5'd3, 16'h0004);
    drive(1'b1, ins, 32'h118, 1'b0, 1'b0, 5'd0, 32'h0);
    q32.push_back(mk(ins, 32'h118, C_LW, 32'h0, 32'h3333, 5'h1F));
    ins = itype(6'h08, 5'd1, 5'd3, 16'hFFFC);
    drive(1'b1, ins, 32'h11C, 1'b0, 1'b0, 5'd0, 32'h0);
    check("addi.no_stall", 32'(stall), 32'd0);
    q32.push_back(mk(ins, 32'h11C, C_ADDI, 32'h0, 32'h3333, 5'h1F));

    // lw r3, 0(r5) then beq r3 with flush: flush beats the hazard
    ins = itype(6'h23, 5'd5, 5'd3, 16'h0000);
    drive(1'b1, ins, 32'h120, 1'b0, 1'b0, 5'd0, 32'h0);
    q32.push_back(mk(ins, 32'h120, C_LW, 32'h1234, 32'h3333, 5'h1F));
    drive(1'b1, itype(6'h04, 5'd3, 5'd4, 16'h0010), 32'h124, 1'b1, 1'b0, 5'd0, 32'h0);
    check("flush.stall", 32'(stall), 32'd0);
    check("flush.jump", 32'(jump), 32'd0);

    // j 0x0100000 with pc4 0x00400008
    ins = {6'h02, 26'h0100000};
    drive(1'b1, ins, 32'h00400008, 1'b0, 1'b0, 5'd0, 32'h0);
    check("j.jump", 32'(jump), 32'd1);
    check("j.target", pc_jump, 32'h00400000);
    check("j.stall", 32'(stall), 32'd0);
    q32.push_back(mk(ins, 32'h00400008, C_NONE, 32'h0, 32'h0, 5'h1F));
    drive(1'b1, ins, 32'h00400008, 1'b1, 1'b0, 5'd0, 32'h0);
    check("j.flushed", 32'(jump), 32'd0);

    // bne, sw (negative imm), unknown opcode, beq
    ins = itype(6'h05, 5'd5, 5'd7, 16'h0010);
    drive(1'b1, ins, 32'h128, 1'b0, 1'b0, 5'd0, 32'h0);
    q32.push_back(mk(ins, 32'h128, C_BNE, 32'h1234, 32'hAA, 5'h1F));
    ins = itype(6'h2B, 5'd3, 5'd7, 16'h8000);
    drive(1'b1, ins, 32'h12C, 1'b0, 1'b0, 5'd0, 32'h0);
    q32.push_back(mk(ins, 32'h12C, C_SW, 32'h3333, 32'hAA, 5'h1F));
    ins = itype(6'h3F, 5'd5, 5'd7, 16'h1234);
    drive(1'b1, ins, 32'h130, 1'b0, 1'b0, 5'd0, 32'h0);
    q32.push_back(mk(ins, 32'h130, C_NONE, 32'h1234, 32'hAA, 5'h1F));
    ins = itype(6'h04, 5'd5, 5'd7, 16'h0001);
    drive(1'b1, ins, 32'h134, 1'b0, 1'b0, 5'd0, 32'h0);
    q32.push_back(mk(ins, 32'h134, C_BEQ, 32'h1234, 32'hAA, 5'h1F));

    // lw r3 then sw using r3 as rt: stall, then async reset mid-cycle
    ins = itype(6'h23, 5'd0, 5'd3, 16'h0000);
    drive(1'b1, ins, 32'h138, 1'b0, 1'b0, 5'd0, 32'h0);
    q32.push_back(mk(ins, 32'h138, C_LW, 32'h0, 32'h3333, 5'h1F));
    ins = itype(6'h2B, 5'd5, 5'd3, 16'h0000);
    drive(1'b1, ins, 32'h13C, 1'b0, 1'b0, 5'd0, 32'h0);
    check("sw.stall", 32'(stall), 32'd1);
    #4;
    reset = 1'b1;
    #1;
    check("arst.ex_valid", 32'(ex_valid), 32'd0);
    check("arst.mem_read", 32'(ex_mem_read), 32'd0);
    check("arst.ex_rt_data", ex_rt_data, 32'd0);
    check("arst.stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    // first post-reset edge decodes the held sw against a cleared file
    q32.push_back(mk(ins, 32'h13C, C_SW, 32'h0, 32'h0, 5'h1F));

    repeat (3) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    check("q32.drained", 32'(q32.size()), 32'd0);
    check("q16.drained", 32'(q16.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
